// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard/stall controller: turns per-stage stall requests into register
// enables and bubble injects, and sequences TLB-miss drain, redirect and handler wait.
module pipe_stall_ctrl #(
    parameter  int NUM_STAGES = 5,
    localparam int STG_W      = $clog2(NUM_STAGES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_STAGES-1:0]   stall_req,
    input  logic [NUM_STAGES-2:0]   miss_req,
    input  logic                    handler_done,
    output logic                    pc_en,
    output logic [NUM_STAGES-2:0]   en,
    output logic [NUM_STAGES-2:0]   bubble,
    output logic                    redirect,
    output logic [STG_W-1:0]        cause_stage,
    output logic                    busy,
    output logic                    double_fault
);

    localparam int NR = NUM_STAGES - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_REDIRECT,
        ST_HANDLER
    } state_t;

    state_t            state_q, state_d;
    logic [STG_W-1:0]  cause_q, cause_d;
    logic [STG_W-1:0]  cnt_q, cnt_d;
    logic              dfault_q, dfault_d;

    logic [NUM_STAGES-1:0] eff_stall;
    logic [NUM_STAGES-1:0] drain_keep;
    logic [NR-1:0]         drain_squash;
    logic [STG_W-1:0]      miss_hi;

    // Oldest stalled stage s: registers below s hold, register s takes a NOP,
    // registers above s advance. Result is {pc_en, en, bubble}.
    function automatic logic [2*NR:0] resolve(input logic [NUM_STAGES-1:0] v);
        logic          has;
        int            s;
        logic [NR-1:0] e;
        logic [NR-1:0] b;
        has = 1'b0;
        s   = 0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (v[j]) begin
                has = 1'b1;
                s   = j;
            end
        end
        for (int i = 0; i < NR; i++) begin
            e[i] = !has || (i >= s);
            b[i] = has && (i == s);
        end
        return {!has, e, b};
    endfunction

    always_comb begin
        miss_hi = '0;
        for (int j = 0; j < NR; j++) begin
            if (miss_req[j]) miss_hi = STG_W'(j);
        end
        for (int j = 0; j < NUM_STAGES; j++) begin
            drain_keep[j] = (j > int'(cause_q));
        end
        for (int j = 0; j < NR; j++) begin
            drain_squash[j] = (j <= int'(cause_q));
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        cnt_d    = cnt_q;
        dfault_d = dfault_q;

        // A miss acts as a stall at its own stage; the oldest of stall and miss wins.
        eff_stall = stall_req | {1'b0, miss_req};
        if (state_q == ST_DRAIN) eff_stall = stall_req & drain_keep;
        {pc_en, en, bubble} = resolve(eff_stall);

        unique case (state_q)
            ST_IDLE: begin
                if (|miss_req) begin
                    state_d = ST_DRAIN;
                    cause_d = miss_hi;
                    cnt_d   = STG_W'(NUM_STAGES - 2) - miss_hi;
                end
            end
            ST_DRAIN: begin
                pc_en  = 1'b0;
                bubble = bubble | drain_squash;
                // Count instructions older than the miss leaving the last register.
                if (en[NR-1]) begin
                    if (cnt_q == '0) state_d = ST_REDIRECT;
                    else             cnt_d   = cnt_q - STG_W'(1);
                end
            end
            ST_REDIRECT: begin
                pc_en   = 1'b1;
                en      = '1;
                bubble  = '1;
                state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (|miss_req)   dfault_d = 1'b1;
                if (handler_done) state_d = ST_IDLE;
            end
        endcase

        if (!reset) begin
            pc_en  = 1'b1;
            en     = '1;
            bubble = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cause_q  <= '0;
            cnt_q    <= '0;
            dfault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            cnt_q    <= cnt_d;
            dfault_q <= dfault_d;
        end
    end

    assign redirect     = (state_q == ST_REDIRECT);
    assign busy         = (state_q != ST_IDLE);
    assign cause_stage  = cause_q;
    assign double_fault = dfault_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios then random traffic, every output
// compared each cycle against a behavioural model of the stall/miss rules.
module tb_pipe_stall_ctrl;

    localparam int N  = 5;
    localparam int NR = N - 1;
    localparam int SW = $clog2(N);

    localparam int P_IDLE    = 0;
    localparam int P_DRAIN   = 1;
    localparam int P_REDIR   = 2;
    localparam int P_HANDLER = 3;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [N-1:0]  stall_req;
    logic [NR-1:0] miss_req;
    logic          handler_done;
    logic          pc_en;
    logic [NR-1:0] en;
    logic [NR-1:0] bubble;
    logic          redirect;
    logic [SW-1:0] cause_stage;
    logic          busy;
    logic          double_fault;

    pipe_stall_ctrl #(.NUM_STAGES(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_req    (stall_req),
        .miss_req     (miss_req),
        .handler_done (handler_done),
        .pc_en        (pc_en),
        .en           (en),
        .bubble       (bubble),
        .redirect     (redirect),
        .cause_stage  (cause_stage),
        .busy         (busy),
        .double_fault (double_fault)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int m_phase = P_IDLE;
    int m_cause = 0;
    int m_left  = 0;
    bit m_df    = 1'b0;
    bit started = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int hi_idx(input logic [31:0] v, input int w);
        int r;
        r = -1;
        for (int j = 0; j < w; j++) if (v[j]) r = j;
        return r;
    endfunction

    // Oldest stall s: everything younger holds, register s gets a NOP.
    task automatic resolve_model(input int s, output logic pc, output logic [NR-1:0] e,
                                 output logic [NR-1:0] b);
        int t;
        if (s < 0) begin
            pc = 1'b1;
            e  = '1;
            b  = '0;
        end else begin
            pc = 1'b0;
            t  = ((1 << NR) - 1) & ~((1 << s) - 1);
            e  = t[NR-1:0];
            t  = (s <= N - 2) ? (1 << s) : 0;
            b  = t[NR-1:0];
        end
    endtask

    // driver: apply one cycle of inputs, check outputs mid-cycle, advance the model
    task automatic cycle(input logic rst_v, input logic [N-1:0] st, input logic [NR-1:0] ms,
                         input logic dn);
        logic          pc;
        logic [NR-1:0] e, b;
        int            s, sm;
        reset        = rst_v;
        stall_req    = st;
        miss_req     = ms;
        handler_done = dn;
        #2;
        if (!rst_v) begin
            pc = 1'b1; e = '1; b = '1;
        end else begin
            case (m_phase)
                P_DRAIN: begin
                    s = -1;
                    for (int j = m_cause + 1; j < N; j++) if (st[j]) s = j;
                    resolve_model(s, pc, e, b);
                    pc = 1'b0;
                    sm = (1 << (m_cause + 1)) - 1;
                    b  = b | sm[NR-1:0];
                end
                P_REDIR: begin
                    pc = 1'b1; e = '1; b = '1;
                end
                default: begin
                    s  = hi_idx(32'(st), N);
                    sm = hi_idx(32'(ms), NR);
                    resolve_model((sm > s) ? sm : s, pc, e, b);
                end
            endcase
        end
        check("pc_en", 32'(pc_en), 32'(pc));
        check("en", 32'(en), 32'(e));
        check("bubble", 32'(bubble), 32'(b));
        if (started) begin
            check("redirect", 32'(redirect), 32'(m_phase == P_REDIR));
            check("busy", 32'(busy), 32'(m_phase != P_IDLE));
            check("cause_stage", 32'(cause_stage), 32'(m_cause));
            check("double_fault", 32'(double_fault), 32'(m_df));
        end
        @(posedge clk);
        if (!rst_v) begin
            m_phase = P_IDLE; m_cause = 0; m_left = 0; m_df = 1'b0;
            started = 1'b1;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    sm = hi_idx(32'(ms), NR);
                    if (sm >= 0) begin
                        m_phase = P_DRAIN;
                        m_cause = sm;
                        m_left  = N - 2 - sm;
                    end
                end
                P_DRAIN: begin
                    if (e[NR-1]) begin
                        if (m_left == 0) m_phase = P_REDIR;
                        else             m_left--;
                    end
                end
                P_REDIR: m_phase = P_HANDLER;
                default: begin
                    if (ms != '0) m_df = 1'b1;
                    if (dn) m_phase = P_IDLE;
                end
            endcase
        end
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, '0, '0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; stall_req = '0; miss_req = '0; handler_done = 1'b0;
        @(posedge clk);
        #1;
        // reset block
        cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b0, 5'b10101, 4'b0110, 1'b1);

        // no requests
        idle_cycles(3);
        // memory-stage stall for 3 cycles, then writeback stall
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'b01000, '0, 1'b0);
        idle_cycles(1);
        for (int i = 0; i < 2; i++) cycle(1'b1, 5'b10000, '0, 1'b0);
        idle_cycles(1);

        // ITLB miss: drain, redirect, handler, return
        cycle(1'b1, '0, 4'b0001, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, '0, '0, 1'b0);
        cycle(1'b1, '0, '0, 1'b1);
        idle_cycles(2);

        // two misses at once, oldest wins; writeback stall delays redirect
        cycle(1'b1, '0, 4'b1001, 1'b0);
        cycle(1'b1, 5'b10011, 4'b0010, 1'b0);
        cycle(1'b1, 5'b10000, '0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, '0, '0, 1'b0);

        // miss inside the handler -> double fault, then reset clears it
        cycle(1'b1, '0, 4'b0100, 1'b0);
        cycle(1'b1, '0, '0, 1'b0);
        cycle(1'b1, '0, '0, 1'b0);
        cycle(1'b0, 5'b01000, 4'b0001, 1'b0);
        idle_cycles(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0]  st;
            logic [NR-1:0] ms;
            logic          dn, rv;
            st = '0;
            for (int j = 0; j < N; j++) st[j] = ($urandom_range(0, 7) == 0);
            ms = ($urandom_range(0, 11) == 0) ? NR'($urandom_range(1, (1 << NR) - 1)) : '0;
            dn = (m_phase == P_HANDLER) ? ($urandom_range(0, 5) == 0)
                                        : ($urandom_range(0, 19) == 0);
            rv = ($urandom_range(0, 199) != 0);
            cycle(rv, st, ms, dn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
